// File: rtl/circuit_pkg.sv
// circuit_pkg: shared width constants for the wide accumulator slice.
package circuit_pkg;
    localparam int W_DEFAULT = 96;
    localparam int SLICE = 32;
endpackage

// File: rtl/circuit_if.sv
// circuit_if: sample-enable, data-in and running-sum bundle for circuit_core.
interface circuit_if import circuit_pkg::*; #(parameter int W = W_DEFAULT) ();
    logic en;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    modport master (output en, output X, input Y);
    modport slave (input en, input X, output Y);
endinterface

// File: rtl/circuit_add.sv
// circuit_add: combinational W-bit modular adder built from rippled SLICE-bit pieces.
module circuit_add import circuit_pkg::*; #(parameter int W = W_DEFAULT) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    localparam int N = (W + SLICE - 1) / SLICE;
    logic [N-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g
        localparam int LO = i * SLICE;
        localparam int WD = (W - LO < SLICE) ? W - LO : SLICE;
        if (i < N - 1) begin : g_mid
            assign {c[i+1], sum[LO+:WD]} = {1'b0, a[LO+:WD]} + {1'b0, b[LO+:WD]} + (WD+1)'(c[i]);
        end else begin : g_top
            // carry out of the top slice is the discarded modular overflow
            assign sum[LO+:WD] = a[LO+:WD] + b[LO+:WD] + WD'(c[i]);
        end
    end
endmodule

// File: rtl/circuit_core.sv
// circuit_core: enabled W-bit accumulator; registered input stage then registered running sum.
module circuit_core import circuit_pkg::*; #(parameter int W = W_DEFAULT) (
    input logic clk,
    input logic rst,
    circuit_if.slave bus
);
    logic [W-1:0] x_q, acc, sum;
    logic v_q;
    circuit_add #(.W(W)) u_add (.a(acc), .b(x_q), .sum(sum));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            v_q <= 1'b0;
            acc <= '0;
        end else begin
            v_q <= bus.en;
            if (bus.en) x_q <= bus.X;
            if (v_q) acc <= sum;
        end
    end
    assign bus.Y = acc;
endmodule

// File: tb/tb_circuit_core.sv
// tb_circuit_core: scoreboard bench; expected Y is the modular sum of all words sampled before the latest edge.
module tb_circuit_core;
    import circuit_pkg::*;
    localparam int W = W_DEFAULT;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] hist[$];
    logic [W-1:0] expq[$];
    circuit_if #(.W(W)) bus ();
    circuit_core #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            logic [W-1:0] e;
            e = expq.pop_front();
            checks++;
            if (bus.Y !== e) begin
                errors++;
                $display("FAIL y_seq got %h want %h at %0t", bus.Y, e, $time);
            end
        end
    end
    function automatic logic [W-1:0] model_sum();
        logic [W-1:0] s = '0;
        foreach (hist[i]) s = s + hist[i];
        return s;
    endfunction
    task automatic step(input logic r, input logic e, input logic [W-1:0] x);
        rst = r;
        bus.en = e;
        bus.X = x;
        if (r) hist.delete();
        expq.push_back(r ? '0 : model_sum());
        if (!r && e) hist.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask
    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction
    initial begin
        logic [W-1:0] ones;
        ones = '1;
        void'($urandom(32'd20240611));
        step(1, 1, W'(5));
        step(1, 1, W'(5));
        step(0, 1, W'(5));
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        step(1, 0, W'(0));
        for (int i = 1; i <= 4; i++) step(0, 1, W'(i));
        for (int i = 0; i < 3; i++) step(0, 0, W'(0));
        step(1, 0, W'(0));
        step(0, 1, ones);
        step(0, 1, W'(2));
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        step(1, 0, W'(0));
        step(0, 1, W'(7));
        step(0, 0, W'(100));
        step(0, 1, W'(9));
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        step(1, 0, W'(0));
        step(0, 1, W'(10));
        step(0, 1, W'(20));
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.Y !== '0) begin
            errors++;
            $display("FAIL async_rst got %h want %h", bus.Y, {W{1'b0}});
        end
        @(negedge clk);
        step(1, 1, W'(4));
        step(0, 1, W'(4));
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        step(1, 0, W'(0));
        for (int i = 0; i < 99; i++) step(0, 1, rand_word());
        step(0, 0, W'(0));
        step(0, 0, W'(0));
        @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0 pending", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/circuit_core.md
Name: circuit_core

Overview:
- W-bit enabled accumulator with a registered input stage.
- Each X word sampled while en is high is added, modulo 2^W, into an internal running sum. The sum is presented on Y.
- Used as a wide-datapath test block; the default width is 96 bits, wider than any native adder, to exercise wide arithmetic.

Parameters:
- W, 96, data width of X, Y and the internal accumulator (W >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- en   input  1  sample enable; X is captured on a rising clk edge while en=1.
- X    input  W  data word to accumulate.
- Y    output W  current accumulated sum (registered).

Behaviour:
- Clocking and reset:
  - There is one clock, clk.
  - Reset rst is asynchronous and active-high.
  - While rst=1, the following hold at zero regardless of clk/en/X: x_q=0, v_q=0, acc=0, so Y=0.
- Stage 1, input register, on each rising clk edge with rst=0:
  - if en=1: x_q <= X, v_q <= 1.
  - if en=0: v_q <= 0, x_q holds.
- Stage 2, accumulator, on each rising clk edge with rst=0:
  - if v_q=1: acc <= (acc + x_q) mod 2^W.
  - if v_q=0: acc holds.
- Output: Y = acc, driven directly from the register with no combinational path from X or en.
- Latency: a word sampled at edge k contributes to Y immediately after edge k+1, i.e. 2 clock cycles from X valid to Y update.
- Throughput: one word per cycle. Back-to-back en=1 for N cycles accumulates all N words with no bubbles.
- Overflow: the carry out of bit W-1 is discarded and the sum wraps silently. There is no saturation and no overflow flag.
- en deasserted: no new samples are taken. A word already in stage 1 is still added on the following edge; the pipeline drains.
- en held high during reset: ignored. The first sample is taken on the first rising edge after rst falls.
- Reset mid-operation: the in-flight word in stage 1 is discarded and the accumulator clears. Accumulation restarts from 0 after release.
- X is don't-care when en=0. X with X/Z bits while en=1 is a bench error, not a design case.
- Unknown/uninitialised state is not allowed after the first reset. The bench applies reset at time 0.

Decomposition:
- Shared package circuit_pkg with:
  - localparam default width W_DEFAULT = 96.
  - no typedefs needed beyond logic [W-1:0] words.
- One natural sub-module: circuit_add, a W-bit parameterised modular adder (sum = a + b, carry dropped).
  - Implementation may split it into 32-bit slices with a rippled carry, but it must remain combinational so latency stays 2 cycles.
- circuit_core instantiates circuit_add between acc and x_q and holds the x_q, v_q and acc registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1 and X=5 -> Y=0 throughout. After release, first X=5 sampled -> Y=5 two edges later.
- Stream: en=1, X = 1, 2, 3, 4 on consecutive edges -> Y sequence after latency = 1, 3, 6, 10. Y then holds at 10 when en=0.
- Wrap (W=96): first X=2^96-1, then X=2 -> Y = 2^96-1, then 1; carry discarded.
- Enable gaps: X=7 (en=1), X=100 (en=0), X=9 (en=1) -> Y goes 7 then 16. The 100 is never added, and Y holds during the gap cycle.
- Mid-stream reset: accumulate 10, 20 (Y=30), then pulse rst asynchronously between edges -> Y drops to 0 immediately without a clock. With en=1, X=4 sampled after release -> Y=4.
- Random: 99 cycles of en=1 with random 96-bit X from a fixed seed -> Y equals the scoreboard sum mod 2^96 at each cycle, offset by 2-cycle latency.
